// File: rtl/midi_msg_encoder.sv
// MIDI message serializer: turns synth events into status/data bytes for the UART,
// with running status that is forgotten after an idle timeout.
module midi_msg_encoder #(
   parameter int unsigned RS_TIMEOUT = 7500000,
   parameter int unsigned TW         = 23
) (
   input  logic       CLOCK_25,
   input  logic       reset_reg_N,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [2:0] ev_type,
   input  logic [3:0] ev_ch,
   input  logic [7:0] ev_data1,
   input  logic [7:0] ev_data2,
   input  logic       rs_en,
   input  logic       midi_out_ready,
   output logic       midi_send_byte,
   output logic [7:0] midi_out_data,
   output logic       busy,
   output logic       ev_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_STATUS = 3'd1;
   localparam logic [2:0] S_DATA1  = 3'd2;
   localparam logic [2:0] S_DATA2  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;

   localparam logic [TW-1:0] TIMEOUT = TW'(RS_TIMEOUT);

   logic [2:0]    state_q, state_d;
   logic [2:0]    next_q, next_d;
   logic [7:0]    status_q, status_d;
   logic [7:0]    d1_q, d1_d;
   logic [7:0]    d2_q, d2_d;
   logic          two_q, two_d;
   logic          rsen_q, rsen_d;
   logic [7:0]    last_status_q, last_status_d;
   logic          rs_valid_q, rs_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          send_q, send_d;
   logic          err_q, err_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [7:0]    ev_status;
   logic          ev_bad;

   always_comb begin
      ev_status = '0;
      ev_bad    = 1'b0;
      case (ev_type)
         3'd0:    ev_status = {4'h8, ev_ch};
         3'd1:    ev_status = {4'h9, ev_ch};
         3'd2:    ev_status = {4'hB, ev_ch};
         3'd3:    ev_status = {4'hC, ev_ch};
         3'd4:    ev_status = {4'hE, ev_ch};
         default: ev_bad    = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      next_d        = next_q;
      status_d      = status_q;
      d1_d          = d1_q;
      d2_d          = d2_q;
      two_d         = two_q;
      rsen_d        = rsen_q;
      last_status_d = last_status_q;
      out_data_d    = out_data_q;
      send_d        = 1'b0;
      err_d         = 1'b0;
      // a status strobe below overrides the timeout clear in the same cycle
      rs_valid_d    = (timer_q == TIMEOUT) ? 1'b0 : rs_valid_q;

      case (state_q)
         S_IDLE: begin
            if (ev_valid) begin
               if (ev_bad) begin
                  err_d = 1'b1;
               end else begin
                  status_d = ev_status;
                  d1_d     = ev_data1 & 8'h7F;
                  d2_d     = ev_data2 & 8'h7F;
                  two_d    = (ev_type != 3'd3);
                  rsen_d   = rs_en;
                  if (rs_en && rs_valid_q && (ev_status == last_status_q))
                     state_d = S_DATA1;
                  else
                     state_d = S_STATUS;
               end
            end
         end
         S_STATUS: begin
            if (midi_out_ready) begin
               send_d        = 1'b1;
               out_data_d    = status_q;
               last_status_d = status_q;
               rs_valid_d    = rsen_q;
               next_d        = S_DATA1;
               state_d       = S_WAIT;
            end
         end
         S_DATA1: begin
            if (midi_out_ready) begin
               send_d     = 1'b1;
               out_data_d = d1_q;
               next_d     = two_q ? S_DATA2 : S_IDLE;
               state_d    = S_WAIT;
            end
         end
         S_DATA2: begin
            if (midi_out_ready) begin
               send_d     = 1'b1;
               out_data_d = d2_q;
               next_d     = S_IDLE;
               state_d    = S_WAIT;
            end
         end
         S_WAIT:  state_d = next_q;
         default: state_d = S_IDLE;
      endcase

      if (send_d)
         timer_d = '0;
      else if (timer_q != TIMEOUT)
         timer_d = timer_q + TW'(1);
      else
         timer_d = timer_q;
   end

   always_ff @(posedge CLOCK_25) begin
      if (!reset_reg_N) begin
         state_q       <= S_IDLE;
         next_q        <= S_IDLE;
         status_q      <= '0;
         d1_q          <= '0;
         d2_q          <= '0;
         two_q         <= 1'b0;
         rsen_q        <= 1'b0;
         last_status_q <= '0;
         rs_valid_q    <= 1'b0;
         out_data_q    <= '0;
         send_q        <= 1'b0;
         err_q         <= 1'b0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         next_q        <= next_d;
         status_q      <= status_d;
         d1_q          <= d1_d;
         d2_q          <= d2_d;
         two_q         <= two_d;
         rsen_q        <= rsen_d;
         last_status_q <= last_status_d;
         rs_valid_q    <= rs_valid_d;
         out_data_q    <= out_data_d;
         send_q        <= send_d;
         err_q         <= err_d;
         timer_q       <= timer_d;
      end
   end

   assign ev_ready       = (state_q == S_IDLE);
   assign busy           = ~ev_ready;
   assign midi_send_byte = send_q;
   assign midi_out_data  = out_data_q;
   assign ev_err         = err_q;

endmodule

// File: tb/tb_midi_msg_encoder.sv
// Bench for midi_msg_encoder: directed scenarios plus random events checked
// against a message-level running-status model.
module tb_midi_msg_encoder;

   localparam int RS_TO = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ev_valid;
   logic       ev_ready;
   logic [2:0] ev_type;
   logic [3:0] ev_ch;
   logic [7:0] ev_data1;
   logic [7:0] ev_data2;
   logic       rs_en;
   logic       midi_out_ready;
   logic       midi_send_byte;
   logic [7:0] midi_out_data;
   logic       busy;
   logic       ev_err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // reference model state
   bit       m_valid = 1'b0;
   bit [7:0] m_last = 8'h00;
   int       last_strobe_cyc = 0;
   logic [7:0] prev_data = 8'h00;

   midi_msg_encoder #(.RS_TIMEOUT(RS_TO), .TW(23)) dut (
      .CLOCK_25      (clk),
      .reset_reg_N   (reset_n),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_type       (ev_type),
      .ev_ch         (ev_ch),
      .ev_data1      (ev_data1),
      .ev_data2      (ev_data2),
      .rs_en         (rs_en),
      .midi_out_ready(midi_out_ready),
      .midi_send_byte(midi_send_byte),
      .midi_out_data (midi_out_data),
      .busy          (busy),
      .ev_err        (ev_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mode 0: ready held high (timing checked), 1: random ready, 2: ready low for 50 cycles
   task automatic run_event(input logic [2:0] typ, input logic [3:0] ch,
                            input logic [7:0] d1, input logic [7:0] d2,
                            input logic rsen, input int mode, input int abort_n);
      logic [7:0] exp_q[$];
      logic [7:0] st;
      bit bad;
      int idx;
      bit done;
      check("ready_before", ev_ready, 1);
      ev_type = typ; ev_ch = ch; ev_data1 = d1; ev_data2 = d2; rs_en = rsen;
      ev_valid = 1'b1;
      if (mode == 2) midi_out_ready = 1'b0;
      @(posedge clk); #1;
      ev_valid = 1'b0;

      if (cyc - last_strobe_cyc > RS_TO + 1) m_valid = 1'b0;
      bad = 1'b0;
      st = 8'h00;
      case (typ)
         3'd0: st = 8'h80 | {4'h0, ch};
         3'd1: st = 8'h90 | {4'h0, ch};
         3'd2: st = 8'hB0 | {4'h0, ch};
         3'd3: st = 8'hC0 | {4'h0, ch};
         3'd4: st = 8'hE0 | {4'h0, ch};
         default: bad = 1'b1;
      endcase

      if (bad) begin
         check("err_pulse", ev_err, 1);
         check("err_ready", ev_ready, 1);
         check("err_no_strobe", midi_send_byte, 0);
         @(posedge clk); #1;
         check("err_one_cycle", ev_err, 0);
         check("err_no_strobe2", midi_send_byte, 0);
         check("err_ready2", ev_ready, 1);
         return;
      end

      if (!(rsen && m_valid && st == m_last)) begin
         exp_q.push_back(st);
         m_last  = st;
         m_valid = rsen;
      end
      exp_q.push_back(d1 & 8'h7F);
      if (typ != 3'd3) exp_q.push_back(d2 & 8'h7F);

      check("err_quiet", ev_err, 0);
      check("busy_after_accept", busy, 1);
      check("no_strobe_t0", midi_send_byte, 0);

      idx = 0;
      done = 1'b0;
      for (int off = 1; off <= 200 && !done; off++) begin
         if (mode == 1) midi_out_ready = ($urandom_range(0, 3) != 0);
         else if (mode == 2) midi_out_ready = (off > 50);
         @(posedge clk); #1;
         if (midi_send_byte) begin
            check("byte_in_range", idx < exp_q.size(), 1);
            if (idx < exp_q.size()) check("byte", midi_out_data, exp_q[idx]);
            if (mode == 0) check("strobe_time", off, 1 + 2 * idx);
            if (mode == 2) check("stall_hold", off > 50, 1);
            prev_data = midi_out_data;
            last_strobe_cyc = cyc;
            idx++;
            if (abort_n != 0 && idx == abort_n) begin
               midi_out_ready = 1'b1;
               return;
            end
         end else begin
            check("data_hold", midi_out_data, prev_data);
         end
         if (ev_ready) begin
            done = 1'b1;
            if (mode == 0) check("ready_time", off, 2 * exp_q.size());
         end
      end
      midi_out_ready = 1'b1;
      check("finished", done, 1);
      check("byte_count", idx, exp_q.size());
      check("busy_inv", busy, !ev_ready);
   endtask

   initial begin
      logic [2:0] rt;
      reset_n = 1'b0; ev_valid = 1'b0; ev_type = '0; ev_ch = '0;
      ev_data1 = '0; ev_data2 = '0; rs_en = 1'b0; midi_out_ready = 1'b1;
      idle(3);
      check("rst_send", midi_send_byte, 0);
      check("rst_data", midi_out_data, 8'h00);
      check("rst_err", ev_err, 0);
      check("rst_ready", ev_ready, 1);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      idle(2);

      // note on, running status repeat, channel change
      run_event(3'd1, 4'd0, 8'h3C, 8'h64, 1'b1, 0, 0);
      run_event(3'd1, 4'd0, 8'h40, 8'h00, 1'b1, 0, 0);
      run_event(3'd1, 4'd1, 8'h3C, 8'h64, 1'b1, 0, 0);
      // pitch bend then program change on the same channel
      run_event(3'd4, 4'd3, 8'hFF, 8'h40, 1'b1, 0, 0);
      run_event(3'd3, 4'd3, 8'h05, 8'h00, 1'b1, 0, 0);
      // running-status timeout
      run_event(3'd1, 4'd0, 8'h10, 8'h20, 1'b1, 0, 0);
      idle(20);
      run_event(3'd1, 4'd0, 8'h11, 8'h21, 1'b1, 0, 0);
      idle(10);
      run_event(3'd1, 4'd0, 8'h12, 8'h22, 1'b1, 0, 0);
      // invalid type, then a stalled CC
      run_event(3'd6, 4'd2, 8'h01, 8'h02, 1'b1, 0, 0);
      run_event(3'd2, 4'd2, 8'h07, 8'h7F, 1'b1, 2, 0);

      // reset between DATA1 and DATA2, with an event presented during reset
      idle(30);
      run_event(3'd1, 4'd5, 8'h22, 8'h33, 1'b1, 0, 2);
      reset_n = 1'b0;
      ev_type = 3'd1; ev_ch = 4'd5; ev_data1 = 8'h22; ev_data2 = 8'h33; rs_en = 1'b1;
      ev_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("mid_rst_send", midi_send_byte, 0);
         check("mid_rst_data", midi_out_data, 8'h00);
         check("mid_rst_err", ev_err, 0);
         check("mid_rst_ready", ev_ready, 1);
         check("mid_rst_busy", busy, 0);
      end
      ev_valid = 1'b0;
      reset_n = 1'b1;
      m_valid = 1'b0; m_last = 8'h00; prev_data = 8'h00;
      repeat (5) begin
         @(posedge clk); #1;
         check("post_rst_quiet", midi_send_byte, 0);
         check("post_rst_ready", ev_ready, 1);
      end
      run_event(3'd1, 4'd5, 8'h22, 8'h33, 1'b1, 0, 0);

      // random events; gaps kept clear of the timeout boundary
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) rt = 3'(5 + $urandom_range(0, 2));
         else rt = 3'($urandom_range(0, 4));
         run_event(rt, 4'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), 0);
         if (rt > 3'd4) idle(30);
         else if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 5)));
         else idle(int'($urandom_range(25, 40)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
